// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage RV64 core: ALU-control decode, ALU, branch compare and
// branch-target add, followed by the negedge-clocked EX/MEM pipeline register.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] PC_addr,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [DATA_W-1:0] imm_val,
    input  logic [3:0]        funct_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              Branch,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              ALUSrc,
    input  logic [1:0]        ALU_op,
    output logic              valid_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic [DATA_W-1:0] branch_target_out,
    output logic              branch_taken_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              MemtoReg_out,
    output logic              RegWrite_out,
    output logic              MemWrite_out,
    output logic              MemRead_out
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_fn_e;

    alu_fn_e           alu_fn;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] branch_target;
    logic              cmp_eq;
    logic              cmp_lt_s;
    logic              cmp_lt_u;
    logic              branch_cond;

    assign op_a  = read_data1;
    assign op_b  = ALUSrc ? imm_val : read_data2;
    assign shamt = op_b[SH_W-1:0];

    // ALU control: unlisted funct codes fall back to add.
    always_comb begin
        alu_fn = ALU_ADD;
        unique case (ALU_op)
            2'b01: alu_fn = ALU_SUB;
            2'b10: begin
                unique case (funct_in)
                    4'b0000: alu_fn = ALU_ADD;
                    4'b1000: alu_fn = ALU_SUB;
                    4'b0111: alu_fn = ALU_AND;
                    4'b0110: alu_fn = ALU_OR;
                    4'b0100: alu_fn = ALU_XOR;
                    4'b0001: alu_fn = ALU_SLL;
                    4'b0101: alu_fn = ALU_SRL;
                    4'b1101: alu_fn = ALU_SRA;
                    default: alu_fn = ALU_ADD;
                endcase
            end
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_result = '0;
        unique case (alu_fn)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_XOR: alu_result = op_a ^ op_b;
            ALU_SLL: alu_result = op_a << shamt;
            ALU_SRL: alu_result = op_a >> shamt;
            ALU_SRA: alu_result = $signed(op_a) >>> shamt;
            default: alu_result = op_a + op_b;
        endcase
    end

    assign cmp_eq   = (op_a == op_b);
    assign cmp_lt_s = ($signed(op_a) < $signed(op_b));
    assign cmp_lt_u = (op_a < op_b);

    // Condition is only meaningful for the branch-compare ALU_op.
    always_comb begin
        branch_cond = 1'b0;
        if (ALU_op == 2'b01) begin
            unique case (funct_in[2:0])
                3'b000:  branch_cond = cmp_eq;
                3'b001:  branch_cond = !cmp_eq;
                3'b100:  branch_cond = cmp_lt_s;
                3'b101:  branch_cond = !cmp_lt_s;
                3'b110:  branch_cond = cmp_lt_u;
                3'b111:  branch_cond = !cmp_lt_u;
                default: branch_cond = 1'b0;
            endcase
        end
    end

    assign branch_target = PC_addr + (imm_val << 1);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out         <= 1'b0;
            alu_result_out    <= '0;
            zero_out          <= 1'b0;
            write_data_out    <= '0;
            branch_target_out <= '0;
            branch_taken_out  <= 1'b0;
            rd_out            <= '0;
            MemtoReg_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            MemWrite_out      <= 1'b0;
            MemRead_out       <= 1'b0;
        end else if (flush) begin
            valid_out         <= 1'b0;
            alu_result_out    <= '0;
            zero_out          <= 1'b0;
            write_data_out    <= '0;
            branch_target_out <= '0;
            branch_taken_out  <= 1'b0;
            rd_out            <= '0;
            MemtoReg_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            MemWrite_out      <= 1'b0;
            MemRead_out       <= 1'b0;
        end else if (!stall) begin
            valid_out         <= in_valid;
            alu_result_out    <= alu_result;
            zero_out          <= (alu_result == '0);
            write_data_out    <= read_data2;
            branch_target_out <= branch_target;
            branch_taken_out  <= Branch & branch_cond & in_valid;
            rd_out            <= rd_in;
            MemtoReg_out      <= MemtoReg & in_valid;
            RegWrite_out      <= RegWrite & in_valid;
            MemWrite_out      <= MemWrite & in_valid;
            MemRead_out       <= MemRead & in_valid;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: driver pushes model-predicted EX/MEM contents per
// negedge, a monitor pops and compares one record after each negedge.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall, flush, in_valid;
    logic [63:0] PC_addr, read_data1, read_data2, imm_val;
    logic [3:0]  funct_in;
    logic [4:0]  rd_in;
    logic        MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc;
    logic [1:0]  ALU_op;
    logic        valid_out, zero_out, branch_taken_out;
    logic [63:0] alu_result_out, write_data_out, branch_target_out;
    logic [4:0]  rd_out;
    logic        MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out;

    typedef struct packed {
        logic        stall, flush, in_valid;
        logic [63:0] pc, rs1, rs2, imm;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic        m2r, rw, br, mw, mr, alusrc;
        logic [1:0]  op;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] alu;
        logic        zero;
        logic [63:0] wd;
        logic [63:0] tgt;
        logic        taken;
        logic [4:0]  rd;
        logic        m2r, rw, mw, mr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_model = '0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    ex_mem_stage #(.DATA_W(64), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .PC_addr(PC_addr), .read_data1(read_data1), .read_data2(read_data2),
        .imm_val(imm_val), .funct_in(funct_in), .rd_in(rd_in),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
        .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrc(ALUSrc), .ALU_op(ALU_op),
        .valid_out(valid_out), .alu_result_out(alu_result_out), .zero_out(zero_out),
        .write_data_out(write_data_out), .branch_target_out(branch_target_out),
        .branch_taken_out(branch_taken_out), .rd_out(rd_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, 64'(valid_out), 64'd0);
        check({tag, ".alu"}, alu_result_out, 64'd0);
        check({tag, ".zero"}, 64'(zero_out), 64'd0);
        check({tag, ".wdata"}, write_data_out, 64'd0);
        check({tag, ".target"}, branch_target_out, 64'd0);
        check({tag, ".taken"}, 64'(branch_taken_out), 64'd0);
        check({tag, ".rd"}, 64'(rd_out), 64'd0);
        check({tag, ".ctrl"}, 64'({MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out}), 64'd0);
    endtask

    // Reference: instruction semantics evaluated directly from the ISA rules.
    function automatic exp_t model_next(input exp_t cur, input stim_t s);
        exp_t        n;
        logic [63:0] a, b, res;
        logic        cond;
        int unsigned sh;
        if (s.flush) return '0;
        if (s.stall) return cur;
        a    = s.rs1;
        b    = s.alusrc ? s.imm : s.rs2;
        sh   = int'(b % 64);
        res  = a + b;
        cond = 1'b0;
        if (s.op == 2'b01) begin
            res = a - b;
            case (s.funct[2:0])
                3'b000:  cond = (a == b);
                3'b001:  cond = (a != b);
                3'b100:  cond = ($signed(a) < $signed(b));
                3'b101:  cond = ($signed(a) >= $signed(b));
                3'b110:  cond = (a < b);
                3'b111:  cond = (a >= b);
                default: cond = 1'b0;
            endcase
        end else if (s.op == 2'b10) begin
            case (s.funct)
                4'b1000: res = a - b;
                4'b0111: res = a & b;
                4'b0110: res = a | b;
                4'b0100: res = a ^ b;
                4'b0001: res = a << sh;
                4'b0101: res = a >> sh;
                4'b1101: res = $signed(a) >>> sh;
                default: res = a + b;
            endcase
        end
        n.valid = s.in_valid;
        n.alu   = res;
        n.zero  = (res == 64'd0);
        n.wd    = s.rs2;
        n.tgt   = s.pc + s.imm * 64'd2;
        n.taken = s.br & cond & s.in_valid;
        n.rd    = s.rd;
        n.m2r   = s.m2r & s.in_valid;
        n.rw    = s.rw & s.in_valid;
        n.mw    = s.mw & s.in_valid;
        n.mr    = s.mr & s.in_valid;
        return n;
    endfunction

    task automatic step(input stim_t s);
        @(posedge clk);
        stall = s.stall; flush = s.flush; in_valid = s.in_valid;
        PC_addr = s.pc; read_data1 = s.rs1; read_data2 = s.rs2; imm_val = s.imm;
        funct_in = s.funct; rd_in = s.rd; MemtoReg = s.m2r; RegWrite = s.rw;
        Branch = s.br; MemWrite = s.mw; MemRead = s.mr; ALUSrc = s.alusrc; ALU_op = s.op;
        cur_model = model_next(cur_model, s);
        exp_q.push_back(cur_model);
    endtask

    function automatic stim_t base();
        stim_t s = '0;
        s.in_valid = 1'b1;
        s.rd = 5'd3;
        return s;
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] v = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: v = 64'($urandom_range(0, 15));
            1: v = -64'($urandom_range(0, 15));
            default: ;
        endcase
        return v;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.stall = ($urandom_range(0, 99) < 15);
        s.flush = ($urandom_range(0, 99) < 8);
        s.in_valid = ($urandom_range(0, 99) < 85);
        s.pc = rand64(); s.rs1 = rand64(); s.imm = rand64();
        s.rs2 = ($urandom_range(0, 3) == 0) ? s.rs1 : rand64();
        s.funct = 4'($urandom_range(0, 15));
        s.rd = 5'($urandom_range(0, 31));
        s.op = 2'($urandom_range(0, 3));
        s.alusrc = 1'($urandom_range(0, 1));
        s.br = (s.op == 2'b01) && ($urandom_range(0, 3) != 0);
        s.m2r = 1'($urandom_range(0, 1)); s.rw = 1'($urandom_range(0, 1));
        s.mw = 1'($urandom_range(0, 1)); s.mr = 1'($urandom_range(0, 1));
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid_out", 64'(valid_out), 64'(e.valid));
                check("alu_result_out", alu_result_out, e.alu);
                check("zero_out", 64'(zero_out), 64'(e.zero));
                check("write_data_out", write_data_out, e.wd);
                check("branch_target_out", branch_target_out, e.tgt);
                check("branch_taken_out", 64'(branch_taken_out), 64'(e.taken));
                check("rd_out", 64'(rd_out), 64'(e.rd));
                check("MemtoReg_out", 64'(MemtoReg_out), 64'(e.m2r));
                check("RegWrite_out", 64'(RegWrite_out), 64'(e.rw));
                check("MemWrite_out", 64'(MemWrite_out), 64'(e.mw));
                check("MemRead_out", 64'(MemRead_out), 64'(e.mr));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        stim_t s;
        {stall, flush, in_valid, MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc} = '0;
        {PC_addr, read_data1, read_data2, imm_val} = '0;
        funct_in = '0; rd_in = '0; ALU_op = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        s = base(); s.op = 2'b10; s.rs1 = 64'd5; s.rs2 = 64'd7; s.rw = 1'b1;
        s.funct = 4'b0000; step(s);
        s.funct = 4'b1000; step(s);
        s.rs1 = 64'h8000_0000_0000_0000; s.rs2 = 64'd4;
        s.funct = 4'b1101; step(s);
        s.funct = 4'b0101; step(s);

        s = base(); s.pc = 64'h100; s.imm = 64'd8; s.br = 1'b1; s.op = 2'b01;
        s.rs1 = 64'd3; s.rs2 = 64'd3; step(s);
        s.rs2 = 64'd4; step(s);

        s = base(); s.alusrc = 1'b1; s.rs1 = 64'h1000; s.imm = -64'd8;
        s.mr = 1'b1; s.m2r = 1'b1; s.rw = 1'b1; step(s);
        s.in_valid = 1'b0; step(s);

        s = base(); s.rw = 1'b1; s.br = 1'b1; s.op = 2'b01; s.rs1 = 64'd9; s.rs2 = 64'd9;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.stall = 1'b1; s.flush = 1'b0; step(s);
        end
        s = rand_stim(); s.stall = 1'b1; s.flush = 1'b1; step(s);

        for (int i = 0; i < 400; i++) step(rand_stim());

        s = rand_stim(); s.stall = 1'b0; s.flush = 1'b0; s.in_valid = 1'b1; step(s);
        s = rand_stim(); s.stall = 1'b1; s.flush = 1'b0; step(s);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid_stall");
        cur_model = '0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 60; i++) step(rand_stim());

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
